// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit framer.
// Holds the FSM state encoding and parity_mode constants.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: count-based FIFO, first-word fall-through read.
// Ports: clk, reset, push/wr_data, pop/rd_data, count, full, empty.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: buffered words framed as start/data/parity/stop.
// Ports: UCLK, reset, bit_tick, data_valid/parallel_data/ready,
//        parity_mode, two_stop, tx, busy, uart_tx_state, fifo_count.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         UCLK,
    input  logic                         reset,
    input  logic                         bit_tick,
    input  logic                         data_valid,
    input  logic [DATA_WIDTH-1:0]        parallel_data,
    output logic                         ready,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    output logic                         tx,
    output logic                         busy,
    output logic [2:0]                   uart_tx_state,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  par_bit;
    logic                  use_par;
    logic                  two_stop_q;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  last_stop;

    assign ready = !full && !reset;
    assign push  = data_valid && ready;

    assign last_stop = (state == ST_STOP1 && !two_stop_q)
                    || (state == ST_STOP2);

    // Pop from idle or at the final stop tick, so back-to-back
    // frames follow with no idle gap.
    assign pop = bit_tick && !reset && !empty
              && ((state == ST_IDLE) || last_stop);

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (UCLK),
        .reset   (reset),
        .push    (push),
        .wr_data (parallel_data),
        .pop     (pop),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge UCLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            use_par    <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (bit_tick) begin
            if (pop) begin
                // Mode inputs are captured here, so mid-frame
                // changes only apply to the next frame.
                shreg      <= rd_data;
                par_bit    <= (^rd_data) ^ (parity_mode == PAR_ODD);
                use_par    <= has_parity(parity_mode);
                two_stop_q <= two_stop;
                state      <= ST_START;
                tx         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx <= 1'b1;
                    end
                    ST_START: begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (use_par) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP1;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP1;
                        tx    <= 1'b1;
                    end
                    ST_STOP1: begin
                        state <= two_stop_q ? ST_STOP2 : ST_IDLE;
                        tx    <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign busy          = (state != ST_IDLE) || !empty;
    assign uart_tx_state = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed testbench for uart_tx_framer.
// Checks reset, framing, parity, FIFO full/drop, tick pacing, abort.
module tb_uart_tx_framer;

    logic       UCLK = 1'b0;
    logic       reset;
    logic       bit_tick;
    logic       data_valid;
    logic [7:0] parallel_data;
    logic       ready;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       tx;
    logic       busy;
    logic [2:0] uart_tx_state;
    logic [3:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 0;
    int tick_cnt = 0;

    always #5 UCLK = ~UCLK;

    uart_tx_framer #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8)
    ) dut (
        .UCLK          (UCLK),
        .reset         (reset),
        .bit_tick      (bit_tick),
        .data_valid    (data_valid),
        .parallel_data (parallel_data),
        .ready         (ready),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .tx            (tx),
        .busy          (busy),
        .uart_tx_state (uart_tx_state),
        .fifo_count    (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge UCLK);
        #1;
        if (tick_div > 1) begin
            tick_cnt = (tick_cnt + 1) % tick_div;
            bit_tick = (tick_cnt == 0);
        end
    endtask

    task automatic push(input logic [7:0] w);
        data_valid    = 1'b1;
        parallel_data = w;
        step();
        data_valid    = 1'b0;
    endtask

    // exp[k] is the k-th bit on the line; each held `period` cycles.
    task automatic frame_chk(input string tag, input logic [15:0] exp,
                             input int len, input int period);
        for (int k = 0; k < len; k++) begin
            for (int p = 0; p < period; p++) begin
                chk(tag, 32'(tx), 32'(exp[k]));
                step();
            end
        end
    endtask

    logic [7:0] words [8];
    int bad;
    bit found;

    initial begin
        reset         = 1'b1;
        bit_tick      = 1'b0;
        data_valid    = 1'b0;
        parallel_data = '0;
        parity_mode   = 2'b00;
        two_stop      = 1'b0;

        step();
        step();
        chk("rst_tx",    32'(tx), 1);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_state", 32'(uart_tx_state), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(ready), 0);
        reset = 1'b0;
        step();
        chk("ready_after_rst", 32'(ready), 1);

        // Even parity, one stop, 0xA5.
        bit_tick    = 1'b1;
        parity_mode = 2'b01;
        two_stop    = 1'b0;
        push(8'hA5);
        chk("a5_count_push", 32'(fifo_count), 1);
        step();
        chk("a5_count_pop", 32'(fifo_count), 0);
        frame_chk("a5_even", 16'h054A, 11, 1);
        chk("a5_busy_end", 32'(busy), 0);
        chk("a5_tx_idle", 32'(tx), 1);

        // Odd parity, two stops, 0x07; modes change mid-frame.
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        push(8'h07);
        step();
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        frame_chk("07_odd2", 16'h0C0E, 12, 1);
        chk("07_busy_end", 32'(busy), 0);

        // Fill the buffer with no ticks; the 9th word is dropped.
        bit_tick = 1'b0;
        words[0] = 8'h01; words[1] = 8'h23;
        words[2] = 8'h45; words[3] = 8'h67;
        words[4] = 8'h89; words[5] = 8'hAB;
        words[6] = 8'hCD; words[7] = 8'hF0;
        for (int i = 0; i < 8; i++) push(words[i]);
        chk("full_ready", 32'(ready), 0);
        chk("full_count", 32'(fifo_count), 8);
        push(8'hEE);
        chk("drop_count", 32'(fifo_count), 8);
        chk("drop_idle", 32'(uart_tx_state), 0);
        bit_tick = 1'b1;
        step();
        chk("burst_count", 32'(fifo_count), 7);
        for (int i = 0; i < 8; i++) begin
            frame_chk("burst", {6'b0, 1'b1, words[i], 1'b0}, 10, 1);
        end
        chk("burst_busy_end", 32'(busy), 0);
        chk("burst_count_end", 32'(fifo_count), 0);

        // Tick every 4th cycle, no parity, 0x3C.
        bit_tick = 1'b0;
        tick_cnt = 0;
        tick_div = 4;
        push(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx === 1'b0) found = 1'b1;
            else step();
        end
        chk("slow_start_seen", 32'(found), 1);
        frame_chk("slow_3c", 16'h0278, 10, 4);
        chk("slow_busy_end", 32'(busy), 0);
        tick_div = 0;

        // Reset during DATA of the first frame with 3 words queued.
        bit_tick    = 1'b0;
        parity_mode = 2'b01;
        for (int i = 0; i < 4; i++) push(8'h00);
        chk("abort_fill", 32'(fifo_count), 4);
        bit_tick = 1'b1;
        step();
        chk("abort_queued", 32'(fifo_count), 3);
        step();
        step();
        chk("abort_in_data", 32'(uart_tx_state), 2);
        chk("abort_tx_low", 32'(tx), 0);
        reset = 1'b1;
        step();
        chk("abort_tx",    32'(tx), 1);
        chk("abort_count", 32'(fifo_count), 0);
        chk("abort_state", 32'(uart_tx_state), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_ready", 32'(ready), 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("abort_no_frames", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 8, meaning the transmit-buffer word count (power of 2, >=2).
REQ-003 UCLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bit_tick  input  1  bit-period strobe; tie high for one bit per UCLK.
REQ-006 data_valid  input  1  write request for parallel_data.
REQ-007 parallel_data  input  DATA_WIDTH  payload word, LSB transmitted first.
REQ-008 ready  output  1  buffer can accept a word; equals not-full, and is 0 while reset is high.
REQ-009 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 two_stop  input  1  1 selects two stop bits.
REQ-011 tx  output  1  registered serial line, idle high.
REQ-012 busy  output  1  high while a frame is in progress or the buffer is non-empty.
REQ-013 uart_tx_state  output  3  current FSM state encoding.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  words buffered.

Function
REQ-015 A word SHALL be written when data_valid && ready; data_valid while not ready SHALL be dropped with no state change.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2, and SHALL advance only on cycles with bit_tick=1.
REQ-017 In IDLE on a bit_tick cycle with fifo_count>0, the block SHALL pop one word, latch it together with parity_mode and two_stop, and enter START, driving tx=0 from the next cycle.
REQ-018 DATA SHALL last DATA_WIDTH ticks, shifting out bits LSB-first via a bit counter that resets on entry.
REQ-019 After DATA, the FSM SHALL enter PARITY if the latched mode is even or odd, otherwise STOP1.
REQ-020 The parity bit SHALL be the XOR of the latched word for even, and its inverse for odd.
REQ-021 STOP1 and STOP2 SHALL drive tx=1; STOP2 SHALL be entered only when latched two_stop=1.
REQ-022 At the final stop tick, if fifo_count>0 the block SHALL pop and go directly to START (no idle gap), otherwise go to IDLE.
REQ-023 Mode inputs changing mid-frame SHALL affect only the next frame.
REQ-024 A simultaneous push and pop SHALL be legal when not full; fifo_count SHALL be unchanged and the popped word SHALL be the oldest.
REQ-025 Writing into an empty buffer SHALL NOT bypass it; the earliest pop is on the following cycle.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from fifo_count.
REQ-027 With bit_tick held high, a frame SHALL span 1+DATA_WIDTH+P+S UCLK cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).

Reset
REQ-028 While reset is high at a clock edge: tx=1, busy=0, state=IDLE, fifo_count=0, pointers=0, bit counter=0.
REQ-029 Reset mid-frame SHALL abort the frame, return tx to 1 on the next cycle, and discard all buffered words.

Structure
REQ-030 The shared package uart_tx_pkg SHALL hold the state encoding and the parity_mode constants.
REQ-031 The buffer SHALL be the sub-module uart_tx_fifo (parameters DATA_WIDTH and FIFO_DEPTH, synchronous-reset); all other logic SHALL reside in uart_tx_framer.

Verification
REQ-032 bit_tick=1, mode even, one stop, push 0xA5 -> tx from the cycle after the pop: 0,1,0,1,0,0,1,0,1,0(parity),1; busy falls after 11 cycles.
REQ-033 Mode odd, two_stop=1, push 0x07 -> parity bit 0, then two stop bits of 1; frame is 12 cycles.
REQ-034 Push 9 words back-to-back with FIFO_DEPTH=8 and no tick -> ready=0 after the 8th word, the 9th is dropped, fifo_count=8; then ticking -> 8 contiguous frames with no idle bits between them.
REQ-035 bit_tick every 4th cycle, mode none, push 0x3C -> each bit holds for 4 cycles; 10 bit periods in total.
REQ-036 Assert reset during DATA of frame 1 with 3 words queued -> tx=1 and fifo_count=0 on the next cycle; no further frames are sent.
